// File: rtl/fighter_pkg.sv
// Shared types and default key maps for the fighter motion sequencer.
// Pressed-vector bit positions are shared by the decoder and the sequencer.
package fighter_pkg;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISE    = 2'd1,
        AIR     = 2'd2,
        RESPAWN = 2'd3
    } move_state_t;

    localparam int KEY_VEC_W    = 5;
    localparam int KEY_IDX_LEFT  = 0;
    localparam int KEY_IDX_RIGHT = 1;
    localparam int KEY_IDX_UP    = 2;
    localparam int KEY_IDX_DOWN  = 3;
    localparam int KEY_IDX_ATK   = 4;

    // Player 1: A / D / W / S / F
    localparam logic [7:0] P1_KEY_LEFT  = 8'h04;
    localparam logic [7:0] P1_KEY_RIGHT = 8'h07;
    localparam logic [7:0] P1_KEY_UP    = 8'h1A;
    localparam logic [7:0] P1_KEY_DOWN  = 8'h16;
    localparam logic [7:0] P1_KEY_ATK   = 8'h09;

    // Player 2: arrow cluster plus M
    localparam logic [7:0] P2_KEY_LEFT  = 8'h50;
    localparam logic [7:0] P2_KEY_RIGHT = 8'h4F;
    localparam logic [7:0] P2_KEY_UP    = 8'h52;
    localparam logic [7:0] P2_KEY_DOWN  = 8'h51;
    localparam logic [7:0] P2_KEY_ATK   = 8'h10;

    // An empty slot (8'h00) never counts as a press, even for a zero key map entry.
    function automatic logic key_in_slots(
        input logic [7:0] key,
        input logic [7:0] s1,
        input logic [7:0] s2,
        input logic [7:0] s3,
        input logic [7:0] s4
    );
        return (key != 8'h00) && ((s1 == key) || (s2 == key) || (s3 == key) || (s4 == key));
    endfunction

endpackage

// File: rtl/key_decode.sv
// Combinational match of the four USB keycode slots against one player's key map.
module key_decode
    import fighter_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT  = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT = P1_KEY_RIGHT,
    parameter logic [7:0] KEY_UP    = P1_KEY_UP,
    parameter logic [7:0] KEY_DOWN  = P1_KEY_DOWN,
    parameter logic [7:0] KEY_ATK   = P1_KEY_ATK
) (
    input  logic [7:0]           keycode_1_i,
    input  logic [7:0]           keycode_2_i,
    input  logic [7:0]           keycode_3_i,
    input  logic [7:0]           keycode_4_i,
    output logic [KEY_VEC_W-1:0] pressed_o
);

    assign pressed_o[KEY_IDX_LEFT]  = key_in_slots(KEY_LEFT,  keycode_1_i, keycode_2_i, keycode_3_i, keycode_4_i);
    assign pressed_o[KEY_IDX_RIGHT] = key_in_slots(KEY_RIGHT, keycode_1_i, keycode_2_i, keycode_3_i, keycode_4_i);
    assign pressed_o[KEY_IDX_UP]    = key_in_slots(KEY_UP,    keycode_1_i, keycode_2_i, keycode_3_i, keycode_4_i);
    assign pressed_o[KEY_IDX_DOWN]  = key_in_slots(KEY_DOWN,  keycode_1_i, keycode_2_i, keycode_3_i, keycode_4_i);
    assign pressed_o[KEY_IDX_ATK]   = key_in_slots(KEY_ATK,   keycode_1_i, keycode_2_i, keycode_3_i, keycode_4_i);

endmodule

// File: rtl/fighter_move_ctrl.sv
// Per-frame motion sequencer for one fighter: jump / air / respawn FSM, attack
// cooldown and key edge tracking. All outputs are registered (one frame latency).
module fighter_move_ctrl
    import fighter_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT       = P1_KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT      = P1_KEY_RIGHT,
    parameter logic [7:0] KEY_UP         = P1_KEY_UP,
    parameter logic [7:0] KEY_DOWN       = P1_KEY_DOWN,
    parameter logic [7:0] KEY_ATK        = P1_KEY_ATK,
    parameter logic [7:0] JUMP_FRAMES    = 8'd20,
    parameter logic [3:0] MAX_JUMPS      = 4'd2,
    parameter logic [7:0] ATK_COOLDOWN   = 8'd15,
    parameter logic [7:0] RESPAWN_FRAMES = 8'd60
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_1_i,
    input  logic [7:0] keycode_2_i,
    input  logic [7:0] keycode_3_i,
    input  logic [7:0] keycode_4_i,
    input  logic       on_ground_i,
    input  logic       death_status_i,
    input  logic       hit_i,
    output logic       move_left_o,
    output logic       move_right_o,
    output logic       rise_o,
    output logic       drop_o,
    output logic       attack_o,
    output logic       invuln_o,
    output logic [1:0] state_o
);

    logic [KEY_VEC_W-1:0] pressed;
    logic key_left, key_right, key_up, key_down, key_atk;
    logic up_edge, atk_edge, hit_taken, frozen;

    move_state_t state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  cooldown_q, cooldown_d;
    logic [3:0]  jump_cnt_q, jump_cnt_d;
    logic        key_up_q, key_atk_q;
    logic        move_left_q, move_left_d;
    logic        move_right_q, move_right_d;
    logic        rise_q, rise_d;
    logic        drop_q, drop_d;
    logic        attack_q, attack_d;
    logic        invuln_q, invuln_d;

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

    key_decode #(
        .KEY_LEFT  (KEY_LEFT),
        .KEY_RIGHT (KEY_RIGHT),
        .KEY_UP    (KEY_UP),
        .KEY_DOWN  (KEY_DOWN),
        .KEY_ATK   (KEY_ATK)
    ) u_key_decode (
        .keycode_1_i (keycode_1_i),
        .keycode_2_i (keycode_2_i),
        .keycode_3_i (keycode_3_i),
        .keycode_4_i (keycode_4_i),
        .pressed_o   (pressed)
    );

    assign key_left  = pressed[KEY_IDX_LEFT];
    assign key_right = pressed[KEY_IDX_RIGHT];
    assign key_up    = pressed[KEY_IDX_UP];
    assign key_down  = pressed[KEY_IDX_DOWN];
    assign key_atk   = pressed[KEY_IDX_ATK];

    assign up_edge   = key_up  & ~key_up_q;
    assign atk_edge  = key_atk & ~key_atk_q;
    assign hit_taken = hit_i & ~invuln_q;

    // Death outranks everything and restarts the respawn window even mid-respawn.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        jump_cnt_d = jump_cnt_q;
        if (death_status_i) begin
            state_d    = RESPAWN;
            timer_d    = RESPAWN_FRAMES;
            jump_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                GROUND: begin
                    jump_cnt_d = 4'd0;
                    if (up_edge) begin
                        state_d    = RISE;
                        timer_d    = JUMP_FRAMES;
                        jump_cnt_d = 4'd1;
                    end else if (!on_ground_i) begin
                        state_d = AIR;
                    end
                end
                RISE: begin
                    if (hit_taken || !key_up || (timer_q <= 8'd1)) begin
                        state_d = AIR;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = sat_dec(timer_q);
                    end
                end
                AIR: begin
                    if (up_edge && (jump_cnt_q < MAX_JUMPS)) begin
                        state_d    = RISE;
                        timer_d    = JUMP_FRAMES;
                        jump_cnt_d = jump_cnt_q + 4'd1;
                    end else if (on_ground_i) begin
                        state_d = GROUND;
                    end
                end
                RESPAWN: begin
                    if (timer_q <= 8'd1) begin
                        state_d    = AIR;
                        timer_d    = 8'd0;
                        jump_cnt_d = 4'd0;
                    end else begin
                        timer_d = sat_dec(timer_q);
                    end
                end
                default: state_d = AIR;
            endcase
        end
    end

    // Outputs describe the state the fighter occupies for the coming frame.
    always_comb begin
        frozen       = (state_d == RESPAWN);
        move_left_d  = key_left  & ~key_right & ~frozen;
        move_right_d = key_right & ~key_left  & ~frozen;
        rise_d       = (state_d == RISE);
        drop_d       = key_down & (state_d == GROUND);
        attack_d     = atk_edge & (cooldown_q == 8'd0) & ~frozen;
        invuln_d     = frozen;
        cooldown_d   = attack_d ? ATK_COOLDOWN : sat_dec(cooldown_q);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= AIR;
            timer_q      <= 8'd0;
            cooldown_q   <= 8'd0;
            jump_cnt_q   <= 4'd0;
            key_up_q     <= 1'b0;
            key_atk_q    <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            rise_q       <= 1'b0;
            drop_q       <= 1'b0;
            attack_q     <= 1'b0;
            invuln_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cooldown_q   <= cooldown_d;
            jump_cnt_q   <= jump_cnt_d;
            key_up_q     <= key_up;
            key_atk_q    <= key_atk;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            rise_q       <= rise_d;
            drop_q       <= drop_d;
            attack_q     <= attack_d;
            invuln_q     <= invuln_d;
        end
    end

    assign move_left_o  = move_left_q;
    assign move_right_o = move_right_q;
    assign rise_o       = rise_q;
    assign drop_o       = drop_q;
    assign attack_o     = attack_q;
    assign invuln_o     = invuln_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fighter_move_ctrl.sv
// Scoreboard bench for fighter_move_ctrl: a frame-level reference model pushes the
// expected output vector each frame; the DUT output is popped and compared after the edge.
module tb_fighter_move_ctrl;

    localparam logic [1:0] S_GROUND  = 2'd0;
    localparam logic [1:0] S_RISE    = 2'd1;
    localparam logic [1:0] S_AIR     = 2'd2;
    localparam logic [1:0] S_RESPAWN = 2'd3;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] kc1, kc2, kc3, kc4;
    logic       on_ground, death, hit;
    logic       move_left, move_right, rise, drop, attack, invuln;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Output vector layout: {state[1:0], invuln, attack, drop, rise, right, left}
    logic [7:0] sb_q[$];
    logic [7:0] cur;

    logic [1:0] m_state;
    logic [7:0] m_timer, m_cd;
    logic [3:0] m_jcnt;
    logic       m_upq, m_atkq;

    fighter_move_ctrl dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode_1_i    (kc1),
        .keycode_2_i    (kc2),
        .keycode_3_i    (kc3),
        .keycode_4_i    (kc4),
        .on_ground_i    (on_ground),
        .death_status_i (death),
        .hit_i          (hit),
        .move_left_o    (move_left),
        .move_right_o   (move_right),
        .rise_o         (rise),
        .drop_o         (drop),
        .attack_o       (attack),
        .invuln_o       (invuln),
        .state_o        (state)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic held(input logic [7:0] k);
        return (kc1 == k) || (kc2 == k) || (kc3 == k) || (kc4 == k);
    endfunction

    task automatic model_reset();
        m_state = S_AIR;
        m_timer = 8'd0;
        m_cd    = 8'd0;
        m_jcnt  = 4'd0;
        m_upq   = 1'b0;
        m_atkq  = 1'b0;
    endtask

    task automatic model_step(output logic [7:0] e);
        logic       l, r, u, d, a, up_e, atk_e, inv, att;
        logic [1:0] ns;
        logic [7:0] nt;
        logic [3:0] nj;
        l = held(8'h04); r = held(8'h07); u = held(8'h1A); d = held(8'h16); a = held(8'h09);
        up_e  = u & ~m_upq;
        atk_e = a & ~m_atkq;
        ns = m_state; nt = m_timer; nj = m_jcnt;
        if (death) begin
            ns = S_RESPAWN; nt = 8'd60; nj = 4'd0;
        end else if (m_state == S_GROUND) begin
            nj = 4'd0;
            if (up_e) begin ns = S_RISE; nt = 8'd20; nj = 4'd1; end
            else if (!on_ground) ns = S_AIR;
        end else if (m_state == S_RISE) begin
            if (hit || !u || m_timer == 8'd1) begin ns = S_AIR; nt = 8'd0; end
            else nt = m_timer - 8'd1;
        end else if (m_state == S_AIR) begin
            if (up_e && m_jcnt < 4'd2) begin ns = S_RISE; nt = 8'd20; nj = m_jcnt + 4'd1; end
            else if (on_ground) ns = S_GROUND;
        end else begin
            if (m_timer == 8'd1) begin ns = S_AIR; nt = 8'd0; nj = 4'd0; end
            else nt = m_timer - 8'd1;
        end
        inv = (ns == S_RESPAWN);
        att = atk_e & (m_cd == 8'd0) & ~inv;
        e = {ns, inv, att, d & (ns == S_GROUND), ns == S_RISE, r & ~l & ~inv, l & ~r & ~inv};
        m_cd    = att ? 8'd15 : ((m_cd == 8'd0) ? 8'd0 : m_cd - 8'd1);
        m_state = ns; m_timer = nt; m_jcnt = nj;
        m_upq   = u;  m_atkq = a;
    endtask

    task automatic step(input string tag);
        logic [7:0] e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge frame_clk);
        #1;
        cur = {state, invuln, attack, drop, rise, move_right, move_left};
        e = sb_q.pop_front();
        check_eq(tag, 32'(cur), 32'(e));
    endtask

    int cnt, moved;

    initial begin
        Reset = 1'b1;
        kc1 = 8'h00; kc2 = 8'h00; kc3 = 8'h00; kc4 = 8'h00;
        on_ground = 1'b0; death = 1'b0; hit = 1'b0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        check_eq("reset_vec", 32'({state, invuln, attack, drop, rise, move_right, move_left}), 32'h80);
        Reset = 1'b0;

        // Land with no keys
        on_ground = 1'b1;
        step("t1_land");
        check_eq("t1_state", 32'(cur[7:6]), 32'(S_GROUND));

        // Ground jump held for 30 frames
        kc1 = 8'h1A; on_ground = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step("t2_hold");
            if (cur[2]) cnt++;
        end
        check_eq("t2_rise_len", cnt, 20);
        check_eq("t2_air", 32'(cur[7:6]), 32'(S_AIR));
        kc1 = 8'h00; step("t2_rel");
        kc1 = 8'h1A; step("t2_air_jump");
        check_eq("t2_second_rise", 32'(cur[2]), 1);
        step("t2_air_jump_hold");
        kc1 = 8'h00; step("t2_rel2");
        kc1 = 8'h1A; step("t2_third");
        check_eq("t2_third_no_rise", 32'(cur[2]), 0);
        kc1 = 8'h00; on_ground = 1'b1; step("t2_land");
        check_eq("t2_ground", 32'(cur[7:6]), 32'(S_GROUND));

        // Opposing directions cancel; drop while grounded
        kc1 = 8'h04; kc3 = 8'h07; step("t3_both");
        check_eq("t3_both_zero", 32'(cur[1:0]), 0);
        kc3 = 8'h00; step("t3_left");
        check_eq("t3_left_only", 32'(cur[1:0]), 1);
        kc1 = 8'h00; kc2 = 8'h16; step("t3_drop");
        check_eq("t3_drop", 32'(cur[3]), 1);
        kc2 = 8'h00; step("t3_drop_rel");

        // Attack: held key yields one pulse, then cooldown window
        kc4 = 8'h09; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step("t4_hold");
            if (cur[4]) cnt++;
        end
        check_eq("t4_one_pulse", cnt, 1);
        kc4 = 8'h00; step("t4_rel");
        kc4 = 8'h09; step("t4_e0");
        check_eq("t4_pulse_e0", 32'(cur[4]), 1);
        kc4 = 8'h00;
        for (int i = 1; i < 10; i++) step("t4_gap1");
        kc4 = 8'h09; step("t4_e10");
        check_eq("t4_blocked_e10", 32'(cur[4]), 0);
        kc4 = 8'h00;
        for (int i = 11; i < 16; i++) step("t4_gap2");
        kc4 = 8'h09; step("t4_e16");
        check_eq("t4_pulse_e16", 32'(cur[4]), 1);
        kc4 = 8'h00; step("t4_done");

        // Death mid-rise, hit ignored during respawn, then fresh jump budget
        kc1 = 8'h1A; on_ground = 1'b0; step("t5_rise");
        step("t5_rise2");
        kc2 = 8'h04; death = 1'b1; step("t5_death");
        death = 1'b0;
        cnt = cur[5] ? 1 : 0;
        moved = 0;
        for (int i = 0; i < 100 && cur[5]; i++) begin
            hit = (i == 20);
            step("t5_respawn");
            if (cur[5]) begin
                cnt++;
                if (cur[4:0] != 5'd0) moved++;
            end
        end
        hit = 1'b0;
        check_eq("t5_invuln_len", cnt, 60);
        check_eq("t5_frozen", moved, 0);
        check_eq("t5_exit_air", 32'(cur[7:6]), 32'(S_AIR));
        kc1 = 8'h00; kc2 = 8'h00; step("t5_rel");
        kc1 = 8'h1A; step("t5_jump1");
        kc1 = 8'h00; step("t5_rel1");
        kc1 = 8'h1A; step("t5_jump2");
        check_eq("t5_jump2_rise", 32'(cur[2]), 1);

        // Asynchronous reset mid-rise
        step("t6_rise");
        @(negedge frame_clk);
        Reset = 1'b1;
        #1;
        check_eq("t6_async_vec", 32'({state, invuln, attack, drop, rise, move_right, move_left}), 32'h80);
        check_eq("t6_async_rise", 32'(rise), 0);
        model_reset();
        kc1 = 8'h00; on_ground = 1'b0;
        #2;
        Reset = 1'b0;
        step("t6_post");
        check_eq("t6_air", 32'(cur[7:6]), 32'(S_AIR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
